// File: rtl/bcd_timing_editor_if.sv
// Button-side / generator-side bundle for bcd_timing_editor.
// master = front end driving edit pulses; slave = the editor itself.
interface bcd_timing_editor_if #(
  parameter int NUM_FIELDS = 2,
  parameter int NUM_DIGITS = 4
);
  localparam int NCELL = NUM_FIELDS * NUM_DIGITS;
  localparam int W     = NCELL * 4;
  localparam int CW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  logic          edit_start;
  logic          edit_commit;
  logic          edit_abort;
  logic          cursor_next;
  logic          adj_up;
  logic          adj_dn;
  logic          sync_load;
  logic [W-1:0]  in_fields;
  logic [W-1:0]  out_fields;
  logic [W-1:0]  work_fields;
  logic [CW-1:0] cursor;
  logic          editing;
  logic          out_update;
  logic          out_reject;

  modport master (
    output edit_start, edit_commit, edit_abort, cursor_next, adj_up, adj_dn,
           sync_load, in_fields,
    input  out_fields, work_fields, cursor, editing, out_update, out_reject
  );

  modport slave (
    input  edit_start, edit_commit, edit_abort, cursor_next, adj_up, adj_dn,
           sync_load, in_fields,
    output out_fields, work_fields, cursor, editing, out_update, out_reject
  );
endinterface

// File: rtl/bcd_timing_editor.sv
// Multi-field BCD timing editor: live fields plus an edit session on a working copy.
// Define BCD_CARRY_EN for carry/borrow adjust across digits; default is per-digit wrap.
module bcd_timing_editor #(
  parameter int NUM_FIELDS     = 2,
  parameter int NUM_DIGITS     = 4,
  parameter logic [NUM_FIELDS*NUM_DIGITS*4-1:0] DEFAULT_BCD = 32'h0008_0002,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  bcd_timing_editor_if.slave bus
);
  localparam int NCELL = NUM_FIELDS * NUM_DIGITS;
  localparam int W     = NCELL * 4;
  localparam int CW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_EDIT} state_t;

  state_t        r_state, w_state_nx;
  logic [W-1:0]  r_live, w_live_nx;
  logic [W-1:0]  r_work, w_work_nx;
  logic [CW-1:0] r_cursor, w_cursor_nx;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic          r_update, w_update_nx;
  logic          r_reject, w_reject_nx;

  logic [W-1:0]  w_clamp;
  logic [W-1:0]  w_adj;
  logic          w_ovf;
  logic          w_adj_req;
  logic          w_tick;

  assign w_adj_req = bus.adj_up ^ bus.adj_dn;

  // External loads may carry non-BCD nibbles; saturate them to 9.
  always_comb begin
    w_clamp = bus.in_fields;
    for (int i = 0; i < NCELL; i++)
      if (bus.in_fields[i*4 +: 4] > 4'd9) w_clamp[i*4 +: 4] = 4'd9;
  end

  // Candidate working copy after an adjust at the cursor.
  always_comb begin
    logic [3:0] nib;
    int         cur;
`ifdef BCD_CARRY_EN
    logic       c;
`endif
    w_adj = r_work;
    w_ovf = 1'b0;
    nib   = 4'd0;
    cur   = int'(r_cursor);
`ifdef BCD_CARRY_EN
    // Carry/borrow ripples from the cursor digit toward the field MSD.
    for (int f = 0; f < NUM_FIELDS; f++) begin
      c = (cur >= f*NUM_DIGITS) && (cur < (f+1)*NUM_DIGITS);
      for (int d = 0; d < NUM_DIGITS; d++) begin
        nib = r_work[(f*NUM_DIGITS+d)*4 +: 4];
        if (c && (f*NUM_DIGITS + d) >= cur) begin
          if (bus.adj_up) begin
            if (nib >= 4'd9) nib = 4'd0;
            else begin nib = nib + 4'd1; c = 1'b0; end
          end else begin
            if (nib == 4'd0) nib = 4'd9;
            else begin nib = nib - 4'd1; c = 1'b0; end
          end
          w_adj[(f*NUM_DIGITS+d)*4 +: 4] = nib;
        end
      end
      if (c) w_ovf = 1'b1;
    end
`else
    for (int i = 0; i < NCELL; i++) begin
      if (i == cur) begin
        nib = r_work[i*4 +: 4];
        if (bus.adj_up) nib = (nib >= 4'd9) ? 4'd0 : nib + 4'd1;
        else            nib = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
        w_adj[i*4 +: 4] = nib;
      end
    end
`endif
  end

  always_comb begin
    w_state_nx  = r_state;
    w_live_nx   = r_live;
    w_work_nx   = r_work;
    w_cursor_nx = r_cursor;
    w_timer_nx  = r_timer;
    w_update_nx = 1'b0;
    w_reject_nx = 1'b0;
    w_tick      = 1'b0;

    if (bus.sync_load) begin
      if (w_clamp == '0) begin
        w_reject_nx = 1'b1;
      end else begin
        w_live_nx   = w_clamp;
        w_work_nx   = w_clamp;
        w_update_nx = (w_clamp != r_live);
        w_state_nx  = S_IDLE;
        w_cursor_nx = '0;
        w_timer_nx  = '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.edit_start) begin
            w_state_nx  = S_EDIT;
            w_work_nx   = r_live;
            w_cursor_nx = '0;
            w_timer_nx  = TMO;
          end
        end
        S_EDIT: begin
          if (bus.edit_abort) begin
            w_work_nx  = r_live;
            w_state_nx = S_IDLE;
            w_timer_nx = '0;
          end else if (bus.edit_commit) begin
            w_live_nx   = r_work;
            w_update_nx = 1'b1;
            w_state_nx  = S_IDLE;
            w_timer_nx  = '0;
          end else if (w_adj_req) begin
            // Refused adjusts do not count as activity for the timeout.
            if (w_ovf || (w_adj == '0)) begin
              w_reject_nx = 1'b1;
              w_tick      = 1'b1;
            end else begin
              w_work_nx  = w_adj;
              w_timer_nx = TMO;
            end
          end else if (bus.cursor_next) begin
            w_cursor_nx = (r_cursor == CW'(NCELL - 1)) ? '0 : r_cursor + CW'(1);
            w_timer_nx  = TMO;
          end else begin
            w_tick = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase

      if (w_tick && (TIMEOUT_CYCLES != 0)) begin
        if (r_timer <= TW'(1)) begin
          w_work_nx  = r_live;
          w_state_nx = S_IDLE;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_live   <= DEFAULT_BCD;
      r_work   <= DEFAULT_BCD;
      r_cursor <= '0;
      r_timer  <= '0;
      r_update <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_live   <= w_live_nx;
      r_work   <= w_work_nx;
      r_cursor <= w_cursor_nx;
      r_timer  <= w_timer_nx;
      r_update <= w_update_nx;
      r_reject <= w_reject_nx;
    end
  end

  assign bus.out_fields  = r_live;
  assign bus.work_fields = r_work;
  assign bus.cursor      = r_cursor;
  assign bus.editing     = (r_state == S_EDIT);
  assign bus.out_update  = r_update;
  assign bus.out_reject  = r_reject;
endmodule

// File: tb/tb_bcd_timing_editor.sv
// Directed scoreboard bench for bcd_timing_editor (2 fields x 4 digits, 16-cycle timeout).
module tb_bcd_timing_editor;
  localparam logic [31:0] DEF = 32'h0008_0002;

  localparam logic [6:0] P_START  = 7'b000_0001;
  localparam logic [6:0] P_COMMIT = 7'b000_0010;
  localparam logic [6:0] P_ABORT  = 7'b000_0100;
  localparam logic [6:0] P_NEXT   = 7'b000_1000;
  localparam logic [6:0] P_UP     = 7'b001_0000;
  localparam logic [6:0] P_DN     = 7'b010_0000;
  localparam logic [6:0] P_SYNC   = 7'b100_0000;

  localparam int O_OUT = 0, O_WORK = 1, O_CUR = 2, O_EDIT = 3, O_UPD = 4, O_REJ = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  bcd_timing_editor_if #(.NUM_FIELDS(2), .NUM_DIGITS(4)) bus ();

  bcd_timing_editor #(
    .NUM_FIELDS(2), .NUM_DIGITS(4), .DEFAULT_BCD(DEF), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_OUT:   return bus.out_fields;
      O_WORK:  return bus.work_fields;
      O_CUR:   return 32'(bus.cursor);
      O_EDIT:  return 32'(bus.editing);
      O_UPD:   return 32'(bus.out_update);
      default: return 32'(bus.out_reject);
    endcase
  endfunction

  task automatic expect_(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic [6:0] p, input logic [31:0] din);
    bus.edit_start  = p[0];
    bus.edit_commit = p[1];
    bus.edit_abort  = p[2];
    bus.cursor_next = p[3];
    bus.adj_up      = p[4];
    bus.adj_dn      = p[5];
    bus.sync_load   = p[6];
    bus.in_fields   = din;
  endtask

  // One clock with the given pulses; returns #1 after the edge.
  task automatic step(input logic [6:0] p, input logic [31:0] din = 32'h0);
    drive(p, din);
    @(posedge clk);
    #1;
    drive(7'b0, 32'h0);
  endtask

  initial begin
    drive(7'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_("rst_out", O_OUT, DEF);   expect_("rst_work", O_WORK, DEF);
    expect_("rst_edit", O_EDIT, 0);   expect_("rst_cur", O_CUR, 0);
    expect_("rst_upd", O_UPD, 0);     expect_("rst_rej", O_REJ, 0);
    drain();

    step(P_START);
    expect_("start_edit", O_EDIT, 1); expect_("start_work", O_WORK, DEF);
    drain();
    step(P_UP);
    expect_("up_work", O_WORK, 32'h0008_0003); expect_("up_out", O_OUT, DEF);
    drain();
    step(P_COMMIT);
    expect_("commit_out", O_OUT, 32'h0008_0003); expect_("commit_upd", O_UPD, 1);
    expect_("commit_edit", O_EDIT, 0);
    drain();
    step(7'b0);
    expect_("upd_one_clk", O_UPD, 0);
    drain();

    step(P_SYNC, 32'h0008_0009);
    expect_("sync9_out", O_OUT, 32'h0008_0009); expect_("sync9_upd", O_UPD, 1);
    drain();
    step(P_START);
    step(P_UP);
`ifdef BCD_CARRY_EN
    expect_("wrap_work", O_WORK, 32'h0008_0010);
`else
    expect_("wrap_work", O_WORK, 32'h0008_0000);
`endif
    expect_("wrap_out", O_OUT, 32'h0008_0009);
    drain();
    step(P_ABORT);
    expect_("abort_work", O_WORK, 32'h0008_0009); expect_("abort_edit", O_EDIT, 0);
    expect_("abort_upd", O_UPD, 0);
    drain();

    step(P_SYNC, 32'h0000_0001);
    step(P_START);
    step(P_DN);
    expect_("zero_rej", O_REJ, 1); expect_("zero_work", O_WORK, 32'h0000_0001);
    drain();
    step(7'b0);
    expect_("rej_one_clk", O_REJ, 0);
    drain();
    step(P_UP | P_DN);
    expect_("both_work", O_WORK, 32'h0000_0001); expect_("both_rej", O_REJ, 0);
    drain();

    repeat (4) step(P_NEXT);
    expect_("cur4", O_CUR, 4);
    drain();
    step(P_UP);
    expect_("f1_up", O_WORK, 32'h0001_0001);
    drain();
    step(P_DN);
    expect_("f1_dn", O_WORK, 32'h0000_0001);
    drain();
    repeat (3) step(P_NEXT);
    expect_("cur7", O_CUR, 7);
    drain();
    step(P_NEXT);
    expect_("cur_wrap", O_CUR, 0);
    drain();
    step(P_UP | P_ABORT);
    expect_("prio_edit", O_EDIT, 0); expect_("prio_work", O_WORK, 32'h0000_0001);
    drain();

    step(P_SYNC, DEF);
    expect_("sync_def_upd", O_UPD, 1);
    drain();
    step(P_START);
    step(P_UP);
    expect_("tmo_up", O_WORK, 32'h0008_0003);
    drain();
    repeat (15) step(7'b0);
    expect_("tmo_still", O_EDIT, 1);
    drain();
    step(7'b0);
    expect_("tmo_edit", O_EDIT, 0); expect_("tmo_work", O_WORK, DEF);
    expect_("tmo_out", O_OUT, DEF);  expect_("tmo_upd", O_UPD, 0);
    drain();

    step(P_SYNC, 32'h0000_0100);
    step(P_START);
    step(P_DN);
`ifdef BCD_CARRY_EN
    expect_("borrow_work", O_WORK, 32'h0000_0099);
`else
    expect_("borrow_work", O_WORK, 32'h0000_0109);
`endif
    drain();
    step(P_ABORT);

    step(P_SYNC, 32'h0000_9999);
    step(P_START);
    step(P_UP);
`ifdef BCD_CARRY_EN
    expect_("ovf_work", O_WORK, 32'h0000_9999); expect_("ovf_rej", O_REJ, 1);
`else
    expect_("ovf_work", O_WORK, 32'h0000_9990); expect_("ovf_rej", O_REJ, 0);
`endif
    drain();

    step(P_SYNC, 32'h00A0_0003);
    expect_("clamp_out", O_OUT, 32'h0090_0003); expect_("clamp_work", O_WORK, 32'h0090_0003);
    expect_("clamp_edit", O_EDIT, 0);          expect_("clamp_upd", O_UPD, 1);
    expect_("clamp_cur", O_CUR, 0);
    drain();
    step(P_SYNC, 32'h0000_0000);
    expect_("sync0_rej", O_REJ, 1); expect_("sync0_out", O_OUT, 32'h0090_0003);
    expect_("sync0_upd", O_UPD, 0);
    drain();

    step(P_START);
    step(P_UP);
    #2 rst_n = 1'b0;
    #1;
    expect_("arst_out", O_OUT, DEF); expect_("arst_work", O_WORK, DEF);
    expect_("arst_edit", O_EDIT, 0);
    drain();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
